// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display driver.
// State encoding, segment codes and the decimal overflow threshold.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low g..a codes, entry 9 first
  localparam logic [9:0][6:0] SEG_TAB = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/alu_result_display_bcd_to_seg.sv
// BCD nibble to active-low seven-segment decoder.
// Ports: nibble in, blank in, seg out (g..a, bit0=a).
module bcd_to_seg
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && nibble <= 4'd9) seg = SEG_TAB[nibble];
  end

endmodule

// File: rtl/alu_result_display.sv
// Double-dabble binary to decimal converter driving DIGITS hex displays.
// Ports: clk, rst_n, in_data/in_valid/in_ready, hex_n, ovf, done.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int IN_W   = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIGITS*7-1:0]   hex_n,
  output logic                  ovf,
  output logic                  done
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);
  localparam longint unsigned LIMIT = pow10(DIGITS);

  state_e              state_q, state_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [DIGITS*7-1:0] hex_q, hex_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W+IN_W-1:0] shifted;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS*7-1:0]   seg_w;
  logic                  seen;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Carries out of the top nibble fall off here
  assign shifted = {bcd_adj, bin_q} << 1;

  // A digit blanks when it and every digit above it are zero
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
      blank[k] = ~seen;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    bcd_to_seg u_seg (
      .nibble (bcd_q[4*k +: 4]),
      .blank  (blank[k]),
      .seg    (seg_w[7*k +: 7])
    );
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    hex_d      = hex_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_data;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(in_data) >= LIMIT);
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = shifted[BCD_W+IN_W-1:IN_W];
        bin_d = shifted[IN_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = LOAD;
      end
      LOAD: begin
        hex_d   = ovf_pend_q ? {DIGITS{SEG_DASH}} : seg_w;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      hex_q      <= {DIGITS{SEG_BLANK}};
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      hex_q      <= hex_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign hex_n    = hex_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule
